// File: rtl/ram_axi_master.sv
// rtl/ram_axi_master.sv - single-beat AXI master bridging a simple RAM request port; optional response watchdog under RAM_AXI_MASTER_TIMEOUT_EN
module ram_axi_master #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk_i,
   input  logic        rst_i,

   input  logic [3:0]  inport_wr_i,
   input  logic        inport_rd_i,
   input  logic [31:0] inport_addr_i,
   input  logic [31:0] inport_write_data_i,
   output logic        inport_accept_o,
   output logic        inport_ack_o,
   output logic        inport_error_o,
   output logic [31:0] inport_read_data_o,

   output logic        axi_awvalid_o,
   output logic [31:0] axi_awaddr_o,
   output logic [7:0]  axi_awlen_o,
   output logic [1:0]  axi_awburst_o,
   input  logic        axi_awready_i,
   output logic        axi_wvalid_o,
   output logic [31:0] axi_wdata_o,
   output logic [3:0]  axi_wstrb_o,
   output logic        axi_wlast_o,
   input  logic        axi_wready_i,
   input  logic        axi_bvalid_i,
   input  logic [1:0]  axi_bresp_i,
   output logic        axi_bready_o,

   output logic        axi_arvalid_o,
   output logic [31:0] axi_araddr_o,
   output logic [7:0]  axi_arlen_o,
   output logic [1:0]  axi_arburst_o,
   input  logic        axi_arready_i,
   input  logic        axi_rvalid_i,
   input  logic [31:0] axi_rdata_i,
   input  logic [1:0]  axi_rresp_i,
   input  logic        axi_rlast_i,
   output logic        axi_rready_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_WRESP,
      S_READ,
      S_RDATA
   } state_t;

   state_t      state_q, state_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic        ack_q, ack_d;
   logic        err_q, err_d;
   logic        take_req;
   logic        rdata_load;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic [31:0] rdata_q;

   logic        aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs;

   // Single-beat INCR bursts only; the last-beat flag from the slave carries no information here
   wire unused_inputs = ^{axi_rlast_i, inport_addr_i[1:0]};

   assign inport_accept_o    = (state_q == S_IDLE);
   assign inport_ack_o       = ack_q;
   assign inport_error_o     = err_q;
   assign inport_read_data_o = rdata_q;

   assign axi_awvalid_o = (state_q == S_WRITE) && !aw_done_q;
   assign axi_wvalid_o  = (state_q == S_WRITE) && !w_done_q;
   assign axi_bready_o  = (state_q == S_WRESP);
   assign axi_arvalid_o = (state_q == S_READ);
   assign axi_rready_o  = (state_q == S_RDATA);

   // Address/data registers are only loaded in IDLE, so payloads stay frozen while any valid is up
   assign axi_awaddr_o  = addr_q;
   assign axi_araddr_o  = addr_q;
   assign axi_awlen_o   = 8'd0;
   assign axi_arlen_o   = 8'd0;
   assign axi_awburst_o = 2'b01;
   assign axi_arburst_o = 2'b01;
   assign axi_wdata_o   = wdata_q;
   assign axi_wstrb_o   = wstrb_q;
   assign axi_wlast_o   = 1'b1;

   assign aw_hs  = axi_awvalid_o && axi_awready_i;
   assign w_hs   = axi_wvalid_o  && axi_wready_i;
   assign b_hs   = axi_bready_o  && axi_bvalid_i;
   assign ar_hs  = axi_arvalid_o && axi_arready_i;
   assign r_hs   = axi_rready_o  && axi_rvalid_i;
   assign any_hs = aw_hs || w_hs || b_hs || ar_hs || r_hs;

`ifdef RAM_AXI_MASTER_TIMEOUT_EN
   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

   logic [31:0] to_cnt_q;
   logic        timeout;

   assign timeout = (state_q != S_IDLE) && !any_hs && (to_cnt_q == TO_LAST);

   // Watchdog: counts cycles spent waiting, restarted by every handshake
   always_ff @(posedge clk_i) begin
      if (rst_i || (state_q == S_IDLE) || any_hs) begin
         to_cnt_q <= 32'd0;
      end else begin
         to_cnt_q <= to_cnt_q + 32'd1;
      end
   end
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   wire unused_hs = any_hs;
`endif

   // Next-state logic: request acceptance, handshake tracking and completion
   always_comb begin
      state_d    = state_q;
      aw_done_d  = aw_done_q;
      w_done_d   = w_done_q;
      ack_d      = 1'b0;
      err_d      = 1'b0;
      take_req   = 1'b0;
      rdata_load = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Write wins when both request types arrive together
            if (inport_wr_i != 4'd0) begin
               state_d   = S_WRITE;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               take_req  = 1'b1;
            end else if (inport_rd_i) begin
               state_d  = S_READ;
               take_req = 1'b1;
            end
         end
         S_WRITE: begin
            aw_done_d = aw_done_q || aw_hs;
            w_done_d  = w_done_q || w_hs;
            if (aw_done_d && w_done_d) begin
               state_d = S_WRESP;
            end
         end
         S_WRESP: begin
            if (b_hs) begin
               state_d = S_IDLE;
               ack_d   = 1'b1;
               err_d   = (axi_bresp_i != 2'b00);
            end
         end
         S_READ: begin
            if (ar_hs) begin
               state_d = S_RDATA;
            end
         end
         S_RDATA: begin
            if (r_hs) begin
               state_d    = S_IDLE;
               ack_d      = 1'b1;
               err_d      = (axi_rresp_i != 2'b00);
               rdata_load = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

`ifdef RAM_AXI_MASTER_TIMEOUT_EN
      if (timeout) begin
         state_d    = S_IDLE;
         ack_d      = 1'b1;
         err_d      = 1'b1;
         rdata_load = 1'b0;
      end
`endif
   end

   // State register and completion pulse
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
      end
   end

   // Request payload capture on acceptance; address is forced word-aligned
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         wstrb_q <= 4'd0;
      end else if (take_req) begin
         addr_q  <= {inport_addr_i[31:2], 2'b00};
         wdata_q <= inport_write_data_i;
         wstrb_q <= inport_wr_i;
      end
   end

   // Read data holds the last completed read; writes never touch it
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata_q <= 32'd0;
      end else if (rdata_load) begin
         rdata_q <= axi_rdata_i;
      end
   end

endmodule
